// File: rtl/apb_pkg.sv
// Shared APB types and widths for the register slave.
// Imported by the slave, its register file and its bench.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_slv_state_e;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB3 bus bundle between a requester and a completer.
// Clock and reset travel as plain ports alongside it.
interface apb_if;
  import apb_pkg::*;

  logic [APB_ADDR_W-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_regfile.sv
// Register storage: one sync write port, one async read port.
// Cleared synchronously while presetn is low.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] regs [NUM_REGS];

  // clear on reset, otherwise commit the selected word
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[widx] <= wdata;
    end
  end

  // index padding for non power-of-two depths reads as zero
  assign rdata = (32'(ridx) < 32'(NUM_REGS)) ? regs[ridx] : '0;

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 completer with a bank of 32-bit registers.
// Fixed wait-state count; all outputs come straight from flops.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic   pclk,
  input logic   presetn,
  apb_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_REGS);

  apb_slv_state_e state, state_d;

  logic [3:0]            wait_cnt, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;

  logic [APB_ADDR_W-1:0] off;
  logic [29:0]           idx;
  logic                  dec_err;
  logic [IDX_W-1:0]      ridx;
  logic [APB_DATA_W-1:0] rdata;
  logic                  we;

  // BASE_ADDR is word aligned, so off[1:0] equals paddr[1:0]
  assign off     = bus.paddr - BASE_ADDR;
  assign idx     = off[31:2];
  assign dec_err = (off[1:0] != 2'b00) ||
                   (idx >= 30'(NUM_REGS));

  // the setup edge reads with the live decode, later edges
  // use the index latched at setup
  assign ridx = (state == IDLE) ? idx[IDX_W-1:0] : idx_q;

  apb_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regs (
    .pclk    (pclk),
    .presetn (presetn),
    .we      (we),
    .widx    (idx_q),
    .wdata   (bus.pwdata),
    .ridx    (ridx),
    .rdata   (rdata)
  );

  // state, counter, decode latch and output flops
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state     <= state_d;
      wait_cnt  <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // next state, wait countdown, completion and write strobe
  always_comb begin
    state_d   = state;
    cnt_d     = wait_cnt;
    idx_d     = idx_q;
    err_d     = err_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    we        = 1'b0;
    unique case (state)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (bus.psel && !bus.penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = idx[IDX_W-1:0];
          err_d   = dec_err;
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = dec_err;
            if (!dec_err && !bus.pwrite) begin
              prdata_d = rdata;
            end
          end
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (bus.penable) begin
          if (pready_q) begin
            we        = bus.pwrite && !err_q;
            state_d   = IDLE;
            cnt_d     = '0;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
          end else begin
            cnt_d = (wait_cnt == 4'd0) ? 4'd0
                                       : wait_cnt - 4'd1;
            if (wait_cnt <= 4'd1) begin
              pready_d  = 1'b1;
              pslverr_d = err_q;
              prdata_d  = '0;
              if (!err_q && !bus.pwrite) begin
                prdata_d = rdata;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: zero-wait and three-wait instances
// share one driver; a scoreboard queue holds expected results.
module tb_apb_reg_slave;
  import apb_pkg::*;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  logic        use3 = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;

  apb_if a0 ();
  apb_if a3 ();

  assign a0.paddr   = paddr;
  assign a0.psel    = psel & ~use3;
  assign a0.penable = penable;
  assign a0.pwrite  = pwrite;
  assign a0.pwdata  = pwdata;
  assign a3.paddr   = paddr;
  assign a3.psel    = psel & use3;
  assign a3.penable = penable;
  assign a3.pwrite  = pwrite;
  assign a3.pwdata  = pwdata;

  apb_reg_slave #(
    .NUM_REGS    (16),
    .WAIT_STATES (0),
    .BASE_ADDR   (32'h0)
  ) dut0 (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (a0)
  );

  apb_reg_slave #(
    .NUM_REGS    (16),
    .WAIT_STATES (3),
    .BASE_ADDR   (32'h0)
  ) dut3 (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (a3)
  );

  wire [31:0] prdata  = use3 ? a3.prdata  : a0.prdata;
  wire        pready  = use3 ? a3.pready  : a0.pready;
  wire        pslverr = use3 ? a3.pslverr : a0.pslverr;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cycles;
    logic        is_rd;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m0 [16];
  logic [31:0] m3 [16];
  int          total = 0;
  int          bad = 0;

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m0[i] = '0;
      m3[i] = '0;
    end
  endtask

  // one full transfer; starts and ends at a falling edge
  task automatic do_xfer(input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input string nm);
    exp_t        e;
    exp_t        g;
    logic        err;
    int          n;
    logic        got;
    logic [31:0] rd;
    logic        er;
    err     = (a[1:0] != 2'b00) || (a[31:2] >= 30'd16);
    e.err   = err;
    e.is_rd = !wr;
    e.cycles = use3 ? 4 : 1;
    e.rdata = '0;
    if (!err) e.rdata = use3 ? m3[a[5:2]] : m0[a[5:2]];
    sbq.push_back(e);
    if (wr && !err) begin
      if (use3) m3[a[5:2]] = d;
      else m0[a[5:2]] = d;
    end
    psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk);
    @(negedge pclk);
    penable = 1'b1;
    n = 0; got = 1'b0; rd = '0; er = 1'b0;
    while (!got && n < 40) begin
      n++;
      if (pready === 1'b1) begin
        got = 1'b1; rd = prdata; er = pslverr;
      end else begin
        @(negedge pclk);
      end
    end
    if (got) @(posedge pclk);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    g = sbq.pop_front();
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout: pready never rose", nm);
    end else begin
      total++;
      if (n !== g.cycles) begin
        bad++;
        $display("FAIL %s latency: got %0d want %0d",
                 nm, n, g.cycles);
      end
      total++;
      if (er !== g.err) begin
        bad++;
        $display("FAIL %s pslverr: got %b want %b",
                 nm, er, g.err);
      end
      if (g.is_rd) begin
        total++;
        if (rd !== g.rdata) begin
          bad++;
          $display("FAIL %s prdata: got %h want %h",
                   nm, rd, g.rdata);
        end
      end
    end
    total++;
    if (pready !== 1'b0 || prdata !== '0 || pslverr !== 1'b0) begin
      bad++;
      $display("FAIL %s post: got rdy=%b d=%h e=%b want 0",
               nm, pready, prdata, pslverr);
    end
  endtask

  task automatic test_reset();
    clear_model();
    repeat (3) @(negedge pclk);
    total++;
    if ({a0.pready, a0.pslverr, a0.prdata,
         a3.pready, a3.pslverr, a3.prdata} !== '0) begin
      bad++;
      $display("FAIL reset_out: got %h/%h want 0",
               a0.prdata, a3.prdata);
    end
    presetn = 1'b1;
    @(negedge pclk);
    use3 = 1'b1;
    do_xfer(1'b1, 32'h8, 32'h1111_2222, "rst_pre_wr");
    psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hAAAA_5555;
    @(posedge pclk);
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    total++;
    if ({a3.pready, a3.pslverr, a3.prdata} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got rdy=%b d=%h want 0",
               a3.pready, a3.prdata);
    end
    presetn = 1'b1;
    psel = 1'b0; penable = 1'b0;
    clear_model();
    @(negedge pclk);
    do_xfer(1'b0, 32'h8, 32'h0, "rst_rd8");
  endtask

  task automatic test_zero_wait();
    use3 = 1'b0;
    do_xfer(1'b1, 32'h4, 32'hDEAD_BEEF, "zw_wr4");
    do_xfer(1'b0, 32'h4, 32'h0, "zw_rd4");
  endtask

  task automatic test_wait_states();
    use3 = 1'b1;
    do_xfer(1'b1, 32'h0, 32'h0BAD_F00D, "ws_wr0");
    do_xfer(1'b0, 32'h0, 32'h0, "ws_rd0");
  endtask

  task automatic test_errors();
    use3 = 1'b0;
    do_xfer(1'b1, 32'h41, 32'h1234, "err_wr41");
    do_xfer(1'b1, 32'h40, 32'h1234, "err_wr40");
    do_xfer(1'b1, 32'h5, 32'h1234, "err_wr5");
    do_xfer(1'b0, 32'h40, 32'h0, "err_rd40");
    do_xfer(1'b0, 32'h4, 32'h0, "err_rd4");
    do_xfer(1'b0, 32'h0, 32'h0, "err_rd0");
    use3 = 1'b1;
    do_xfer(1'b0, 32'h42, 32'h0, "err3_rd42");
  endtask

  task automatic test_back_to_back();
    use3 = 1'b0;
    do_xfer(1'b1, 32'h0, 32'h1000_0001, "b2b_wr0");
    do_xfer(1'b1, 32'h4, 32'h2000_0002, "b2b_wr4");
    do_xfer(1'b1, 32'h8, 32'h3000_0003, "b2b_wr8");
    do_xfer(1'b0, 32'h0, 32'h0, "b2b_rd0");
    do_xfer(1'b0, 32'h4, 32'h0, "b2b_rd4");
    do_xfer(1'b0, 32'h8, 32'h0, "b2b_rd8");
    use3 = 1'b1;
    do_xfer(1'b1, 32'h3C, 32'hCAFE_0001, "b2b3_wr3c");
    do_xfer(1'b0, 32'h3C, 32'h0, "b2b3_rd3c");
  endtask

  task automatic test_abort();
    use3 = 1'b1;
    do_xfer(1'b1, 32'hC, 32'h0000_0012, "ab_wr_c");
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hFFFF_FFFF;
    @(posedge pclk);
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    repeat (2) begin
      @(negedge pclk);
      total++;
      if (pready !== 1'b0) begin
        bad++;
        $display("FAIL abort_rdy: got %b want 0", pready);
      end
    end
    do_xfer(1'b0, 32'hC, 32'h0, "ab_rd_c");
  endtask

  task automatic test_stray_penable();
    use3 = 1'b0;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b1;
    pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h5555_5555;
    repeat (3) begin
      @(negedge pclk);
      total++;
      if (pready !== 1'b0) begin
        bad++;
        $display("FAIL stray_rdy: got %b want 0", pready);
      end
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    do_xfer(1'b0, 32'h4, 32'h0, "stray_rd4");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_abort();
    test_stray_penable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

- Synthesizable APB completer: a bank of 32-bit read/write registers behind the APB bus.
- It is the RTL counterpart to the bus master that drives `paddr`/`psel`/`penable`/`pwrite`/`pwdata`. It answers on `prdata` and adds APB3 `pready`/`pslverr`.
- A programmable wait-state count exercises stalled transfers.
- It is the DUT that the master driver and passive monitor are pointed at.

## Interface

Parameters:
- `NUM_REGS`, 16 — number of 32-bit registers (1..256).
- `WAIT_STATES`, 0 — access cycles with `pready`=0 before completion (0..15).
- `BASE_ADDR`, 32'h0000_0000 — byte address of register 0; must be 4-byte aligned.

Ports:
- `pclk` in 1 — sole clock; all logic on the rising edge.
- `presetn` in 1 — reset, synchronous, active-low.
- `paddr` in 32 — byte address.
- `psel` in 1 — slave select.
- `penable` in 1 — access phase.
- `pwrite` in 1 — 1 = write, 0 = read.
- `pwdata` in 32 — write data.
- `prdata` out 32 — read data; valid only while `pready`=1 on a read.
- `pready` out 1 — transfer completes on an edge where `psel`&`penable`&`pready`=1.
- `pslverr` out 1 — error flag; valid only while `pready`=1.

## Operation

- FSM states: IDLE, ACCESS.
- IDLE → ACCESS on an edge sampling `psel`=1, `penable`=0 (setup phase). On that edge:
  - load `wait_cnt` = `WAIT_STATES`;
  - decode the address;
  - if `WAIT_STATES`=0, register `pready`=1, `prdata`, and `pslverr`.
- ACCESS with `pready`=0, `psel`=1, `penable`=1:
  - decrement `wait_cnt`;
  - when `wait_cnt` hits 1 on that edge, register `pready`=1 along with `prdata`/`pslverr`.
- ACCESS with `pready`=1 and `psel`&`penable` sampled:
  - completion;
  - write commits `pwdata` to the register if no error;
  - `pready`, `pslverr`, and `prdata` return to 0;
  - next state is IDLE.
- Address decode:
  - `off` = `paddr` − `BASE_ADDR` (32-bit, wraps);
  - `idx` = `off`[31:2].
- Error conditions:
  - `paddr`[1:0] ≠ 0, or `idx` ≥ `NUM_REGS`, sets `pslverr`=1.
  - On an error read, `prdata`=0.
  - On an error write, no register changes.
- Abort: `psel`=0 while in ACCESS before completion returns to IDLE. There is no write and outputs go to 0.
- Stray `penable`=1 in IDLE without a prior setup is ignored: FSM stays IDLE, `pready` stays 0.
- Back-to-back transfers: a new setup phase in the cycle immediately after completion is accepted normally. There is no turnaround cycle.

## Timing

- Reset: at the edge sampling `presetn`=0, this block applies the following, even mid-transfer:
  - FSM → IDLE, `wait_cnt`=0;
  - all registers = 0;
  - `prdata`=0, `pready`=0, `pslverr`=0;
  - a pending write is dropped.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Transfer latency, setup edge to completion edge: 1 + `WAIT_STATES` access cycles. For `WAIT_STATES`=0 the transfer takes 2 cycles total.
- Read data reflects register contents at the edge that raises `pready`. A write completing on edge N is visible to a read whose `pready`-raising edge is N+1 or later.
- `paddr`, `pwrite`, and `pwdata` are held stable by the master from setup through completion. The slave samples `pwdata` at the completion edge.

## Structure

- Shared package `apb_pkg`:
  - `APB_ADDR_W`=32, `APB_DATA_W`=32;
  - `typedef enum logic {IDLE, ACCESS} apb_slv_state_e`.
- Sub-module `apb_regfile`:
  - `NUM_REGS`×32 storage with synchronous write port (`we`, `widx`, `wdata`);
  - asynchronous read port (`ridx` → `rdata`);
  - synchronous active-low clear on `presetn`.
- `apb_reg_slave` holds the FSM, wait counter, decode, and output registers.

## Test plan

- **Reset:** hold `presetn`=0 for 2 cycles mid-write to `BASE_ADDR`+0x8 (`WAIT_STATES`=3).
  - Outputs are 0.
  - A read of 0x8 afterward returns 0.
- **Zero-wait write/read:** `WAIT_STATES`=0, write 0xDEAD_BEEF to 0x4, then read 0x4.
  - Each transfer takes 2 cycles.
  - `prdata`=0xDEAD_BEEF.
  - `pslverr`=0.
- **Wait states:** `WAIT_STATES`=3, read 0x0.
  - `pready` is low for exactly 3 access cycles, high on the 4th.
  - Total 5 cycles.
- **Errors:**
  - Write 0x1234 to 0x41 (misaligned), then to 0x40 with `NUM_REGS`=16 (out of range): `pslverr`=1 with `pready`, no register modified.
  - Read of 0x40 returns `prdata`=0, `pslverr`=1.
- **Back-to-back and abort:**
  - Writes to 0x0, 0x4, 0x8 with no idle gap all complete.
  - Drop `psel` during a wait state of a write to 0xC: 0xC keeps its old value and the FSM returns to IDLE.
- **Stray `penable`:** `penable`=1, `psel`=1 in IDLE with no setup phase.
  - `pready` stays 0.
  - No register change.
